cc_level_sequencer: RTL and testbench

CC_LEVEL_SEQUENCER -- requirements
Module: CC_LEVEL_SEQUENCER

---
 rtl/cc_level_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_cc_level_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_level_sequencer.sv
// Level row sequencer: emits LFSR-generated obstacle rows per tick,
// walking through levels of growing length with a valid/ready handoff.
module cc_level_sequencer #(
  parameter int          LANE_WIDTH   = 8,
  parameter int          ACTIVE_LANES = 5,
  parameter int          LEVELS       = 3,
  parameter int          BASE_ROWS    = 10,
  parameter int          ROW_STEP     = 5,
  parameter logic [15:0] SEED         = 16'hACE1,
  localparam int LW = (LEVELS > 1) ? $clog2(LEVELS) : 1,
  localparam int PW = $clog2(BASE_ROWS + (LEVELS - 1) * ROW_STEP + 1)
) (
  input  logic                  CC_LEVEL_SEQUENCER_CLOCK_50,
  input  logic                  CC_LEVEL_SEQUENCER_RESET_InLow,
  input  logic                  CC_LEVEL_SEQUENCER_Start_In,
  input  logic [LW-1:0]         CC_LEVEL_SEQUENCER_StartLevel_In,
  input  logic                  CC_LEVEL_SEQUENCER_Abort_In,
  input  logic                  CC_LEVEL_SEQUENCER_Tick_In,
  input  logic                  CC_LEVEL_SEQUENCER_Ready_In,
  output logic [LANE_WIDTH-1:0] CC_LEVEL_SEQUENCER_Row_OutBus,
  output logic                  CC_LEVEL_SEQUENCER_Valid_Out,
  output logic [PW-1:0]         CC_LEVEL_SEQUENCER_Progress_Out,
  output logic [LW-1:0]         CC_LEVEL_SEQUENCER_Level_Out,
  output logic                  CC_LEVEL_SEQUENCER_LevelDone_Out,
  output logic                  CC_LEVEL_SEQUENCER_GameDone_Out,
  output logic                  CC_LEVEL_SEQUENCER_Overflow_Out
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    LEVEL_END,
    DONE
  } state_t;

  localparam logic [15:0] MASK = 16'hB400;
  localparam logic [LW-1:0] LAST_LVL = LW'(LEVELS - 1);
  localparam logic [LANE_WIDTH-1:0] ACT_MASK =
    LANE_WIDTH'((32'd1 << ACTIVE_LANES) - 32'd1);
  localparam logic [LANE_WIDTH-1:0] ONE = LANE_WIDTH'(1);

  logic clk;
  logic rst_n;
  logic start;
  logic abort;
  logic tick;
  logic ready;

  assign clk   = CC_LEVEL_SEQUENCER_CLOCK_50;
  assign rst_n = CC_LEVEL_SEQUENCER_RESET_InLow;
  assign start = CC_LEVEL_SEQUENCER_Start_In;
  assign abort = CC_LEVEL_SEQUENCER_Abort_In;
  assign tick  = CC_LEVEL_SEQUENCER_Tick_In;
  assign ready = CC_LEVEL_SEQUENCER_Ready_In;

  state_t                state_q;
  state_t                state_d;
  logic [15:0]           lfsr_q;
  logic [LANE_WIDTH-1:0] row_q;
  logic                  valid_q;
  logic [PW-1:0]         prog_q;
  logic [LW-1:0]         level_q;
  logic                  ovf_q;

  logic                  in_run;
  logic                  start_ok;
  logic                  accept;
  logic                  last_acc;
  logic                  take;
  logic                  drop;
  logic                  level_done;
  logic                  game_done;
  logic [LW-1:0]         start_lvl;
  logic [PW-1:0]         level_len;
  logic [15:0]           lfsr_nx;
  logic [7:0]            lane_a;
  logic [7:0]            lane_b;
  logic [7:0]            raw;
  logic [LANE_WIDTH-1:0] pat_raw;
  logic [LANE_WIDTH-1:0] pat;
  logic [PW-1:0]         lane_idx;

  // Zero seeds would lock the LFSR, so fall back to the base seed.
  function automatic logic [15:0] seed_for(input logic [LW-1:0] lv);
    logic [15:0] s;
    s = SEED ^ {4{4'(lv)}};
    return (s == 16'h0) ? SEED : s;
  endfunction

  assign start_lvl =
    (CC_LEVEL_SEQUENCER_StartLevel_In > LAST_LVL) ?
    LAST_LVL : CC_LEVEL_SEQUENCER_StartLevel_In;

  assign level_len = PW'(BASE_ROWS) + PW'(ROW_STEP) * PW'(level_q);

  assign in_run   = (state_q == RUN);
  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
  assign accept   = valid_q && ready;
  assign last_acc = in_run && accept && (prog_q == level_len);
  assign take     = in_run && tick && (!valid_q || ready) && !last_acc;
  assign drop     = in_run && tick && valid_q && !ready;

  assign lfsr_nx = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? MASK : 16'h0);
  assign lane_a  = lfsr_nx[7:0];
  assign lane_b  = lfsr_nx[15:8];

  always_comb begin
    raw = lane_a | lane_b;
    if (level_q == LW'(0)) begin
      raw = lane_a & lane_b;
    end else if (level_q == LW'(1)) begin
      raw = lane_a;
    end
  end

  // A fully blocked row always leaves the lane indexed by the row number open.
  always_comb begin
    pat_raw  = raw[LANE_WIDTH-1:0] & ACT_MASK;
    lane_idx = prog_q % PW'(ACTIVE_LANES);
    pat      = pat_raw;
    if (pat_raw == ACT_MASK) begin
      pat = pat_raw & ~(ONE << lane_idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:      if (start) state_d = RUN;
        RUN:       if (last_acc) state_d = LEVEL_END;
        LEVEL_END: state_d = (level_q == LAST_LVL) ? DONE : RUN;
        DONE:      if (start) state_d = RUN;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    level_done = 1'b0;
    game_done  = 1'b0;
    unique case (state_q)
      LEVEL_END: level_done = 1'b1;
      DONE:      game_done  = 1'b1;
      default: begin
        level_done = 1'b0;
        game_done  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q  <= SEED;
      row_q   <= '0;
      valid_q <= 1'b0;
      prog_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else if (abort) begin
      valid_q <= 1'b0;
      prog_q  <= '0;
    end else if (start_ok) begin
      level_q <= start_lvl;
      lfsr_q  <= seed_for(start_lvl);
      prog_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (in_run) begin
      if (take) begin
        lfsr_q  <= lfsr_nx;
        prog_q  <= prog_q + PW'(1);
        row_q   <= pat;
        valid_q <= 1'b1;
      end else if (accept) begin
        valid_q <= 1'b0;
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end else if (state_q == LEVEL_END) begin
      valid_q <= 1'b0;
      if (level_q != LAST_LVL) begin
        level_q <= level_q + LW'(1);
        prog_q  <= '0;
        lfsr_q  <= seed_for(level_q + LW'(1));
      end
    end
  end

  assign CC_LEVEL_SEQUENCER_Row_OutBus     = row_q;
  assign CC_LEVEL_SEQUENCER_Valid_Out      = valid_q;
  assign CC_LEVEL_SEQUENCER_Progress_Out   = prog_q;
  assign CC_LEVEL_SEQUENCER_Level_Out      = level_q;
  assign CC_LEVEL_SEQUENCER_LevelDone_Out  = level_done;
  assign CC_LEVEL_SEQUENCER_GameDone_Out   = game_done;
  assign CC_LEVEL_SEQUENCER_Overflow_Out   = ovf_q;

endmodule

// File: tb/tb_cc_level_sequencer.sv
// Directed bench for cc_level_sequencer with a reference LFSR row model.
module tb_cc_level_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] start_lvl;
  logic       abort;
  logic       tick;
  logic       ready;
  logic [7:0] row;
  logic       valid;
  logic [4:0] prog;
  logic [1:0] level;
  logic       ld;
  logic       gd;
  logic       ov;

  int checks;
  int errors;
  int ld_cnt;
  logic [15:0] m_lfsr;
  logic [7:0]  exp_row;
  logic [7:0]  r1;
  logic [7:0]  rec [1:6];

  cc_level_sequencer dut (
    .CC_LEVEL_SEQUENCER_CLOCK_50      (clk),
    .CC_LEVEL_SEQUENCER_RESET_InLow   (rst_n),
    .CC_LEVEL_SEQUENCER_Start_In      (start),
    .CC_LEVEL_SEQUENCER_StartLevel_In (start_lvl),
    .CC_LEVEL_SEQUENCER_Abort_In      (abort),
    .CC_LEVEL_SEQUENCER_Tick_In       (tick),
    .CC_LEVEL_SEQUENCER_Ready_In      (ready),
    .CC_LEVEL_SEQUENCER_Row_OutBus    (row),
    .CC_LEVEL_SEQUENCER_Valid_Out     (valid),
    .CC_LEVEL_SEQUENCER_Progress_Out  (prog),
    .CC_LEVEL_SEQUENCER_Level_Out     (level),
    .CC_LEVEL_SEQUENCER_LevelDone_Out (ld),
    .CC_LEVEL_SEQUENCER_GameDone_Out  (gd),
    .CC_LEVEL_SEQUENCER_Overflow_Out  (ov)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (ld) ld_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] step16(input logic [15:0] s);
    logic [15:0] h;
    h = s >> 1;
    return s[0] ? (h ^ 16'hB400) : h;
  endfunction

  function automatic logic [15:0] seed_of(input int lv);
    logic [15:0] r;
    r = 16'hACE1 ^ (16'h1111 * 16'(lv));
    return (r == 16'h0) ? 16'hACE1 : r;
  endfunction

  function automatic logic [7:0] gen(input logic [15:0] s,
                                     input int lv,
                                     input int p);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] m;
    a = s[7:0];
    b = s[15:8];
    if (lv == 0)      m = a & b;
    else if (lv == 1) m = a;
    else              m = a | b;
    m = m & 8'h1f;
    if (m == 8'h1f) m = m & ~(8'h01 << ((p - 1) % 5));
    return m;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input int lv, input int p);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    m_lfsr  = step16(m_lfsr);
    exp_row = gen(m_lfsr, lv, p);
    chk("tick_prog", 32'(prog), 32'(p));
    chk("tick_valid", 32'(valid), 32'd1);
    chk("tick_row", 32'(row), 32'(exp_row));
    chk("row_hi_zero", 32'(row[7:5]), 32'd0);
    chk("free_lane", 32'(row[4:0] == 5'h1f), 32'd0);
  endtask

  task automatic start_game(input logic [1:0] sl, input int exp_lvl);
    start     = 1'b1;
    start_lvl = sl;
    cyc();
    start = 1'b0;
    chk("start_level", 32'(level), 32'(exp_lvl));
    chk("start_prog", 32'(prog), 32'd0);
    chk("start_valid", 32'(valid), 32'd0);
    chk("start_ovf", 32'(ov), 32'd0);
    m_lfsr = seed_of(exp_lvl);
  endtask

  task automatic play_level(input int lv, input int n);
    for (int i = 1; i <= n; i++) do_tick(lv, i);
    cyc();
    chk("lend_pulse", 32'(ld), 32'd1);
    chk("lend_valid", 32'(valid), 32'd0);
    chk("lend_level", 32'(level), 32'(lv));
    cyc();
    chk("lend_pulse_off", 32'(ld), 32'd0);
    if (lv < 2) begin
      chk("next_level", 32'(level), 32'(lv + 1));
      chk("next_prog", 32'(prog), 32'd0);
      m_lfsr = seed_of(lv + 1);
    end else begin
      chk("game_done", 32'(gd), 32'd1);
    end
  endtask

  task automatic do_abort();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    ld_cnt    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    start_lvl = 2'd0;
    abort     = 1'b0;
    tick      = 1'b0;
    ready     = 1'b1;
    m_lfsr    = 16'hACE1;
    #25;
    chk("rst_row", 32'(row), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_prog", 32'(prog), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ld", 32'(ld), 32'd0);
    chk("rst_gd", 32'(gd), 32'd0);
    chk("rst_ovf", 32'(ov), 32'd0);
    rst_n = 1'b1;
    cyc();

    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("idle_tick_prog", 32'(prog), 32'd0);
    chk("idle_tick_valid", 32'(valid), 32'd0);
    chk("idle_tick_ovf", 32'(ov), 32'd0);

    ld_cnt = 0;
    start_game(2'd0, 0);
    play_level(0, 10);
    play_level(1, 15);
    play_level(2, 20);
    chk("ld_count", 32'(ld_cnt), 32'd3);
    chk("done_level", 32'(level), 32'd2);
    tick = 1'b1;
    repeat (5) cyc();
    tick = 1'b0;
    chk("done_prog", 32'(prog), 32'd20);
    chk("done_ovf", 32'(ov), 32'd0);
    chk("done_valid", 32'(valid), 32'd0);
    chk("done_gd", 32'(gd), 32'd1);

    start_game(2'd0, 0);
    chk("restart_gd", 32'(gd), 32'd0);
    ready = 1'b0;
    tick  = 1'b1;
    cyc();
    m_lfsr = step16(m_lfsr);
    r1     = gen(m_lfsr, 0, 1);
    repeat (2) cyc();
    tick = 1'b0;
    chk("bp_prog", 32'(prog), 32'd1);
    chk("bp_row", 32'(row), 32'(r1));
    chk("bp_valid", 32'(valid), 32'd1);
    chk("bp_ovf", 32'(ov), 32'd1);
    start     = 1'b1;
    start_lvl = 2'd2;
    cyc();
    start = 1'b0;
    chk("run_start_level", 32'(level), 32'd0);
    chk("run_start_prog", 32'(prog), 32'd1);
    chk("run_start_ovf", 32'(ov), 32'd1);
    ready = 1'b1;
    do_tick(0, 2);
    cyc();
    chk("accept_valid", 32'(valid), 32'd0);
    chk("accept_prog", 32'(prog), 32'd2);
    do_abort();
    chk("abort_ovf_held", 32'(ov), 32'd1);
    chk("abort_prog", 32'(prog), 32'd0);

    start_game(2'd1, 1);
    for (int i = 1; i <= 7; i++) do_tick(1, i);
    abort = 1'b1;
    tick  = 1'b1;
    start = 1'b1;
    cyc();
    abort = 1'b0;
    tick  = 1'b0;
    start = 1'b0;
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_prog7", 32'(prog), 32'd0);
    chk("abort_level", 32'(level), 32'd1);
    chk("abort_idle_gd", 32'(gd), 32'd0);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("abort_idle_tick", 32'(prog), 32'd0);
    start_game(2'd3, 2);
    do_tick(2, 1);

    do_abort();
    start_game(2'd0, 0);
    for (int i = 1; i <= 6; i++) begin
      do_tick(0, i);
      rec[i] = row;
    end
    do_abort();
    start_game(2'd0, 0);
    for (int i = 1; i <= 6; i++) begin
      do_tick(0, i);
      chk("det_repeat", 32'(row), 32'(rec[i]));
    end

    do_abort();
    start_game(2'd1, 1);
    for (int i = 1; i <= 3; i++) do_tick(1, i);
    #4;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_row", 32'(row), 32'd0);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_prog", 32'(prog), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_ld", 32'(ld), 32'd0);
    chk("mid_rst_gd", 32'(gd), 32'd0);
    chk("mid_rst_ovf", 32'(ov), 32'd0);
    @(posedge clk);
    #5;
    rst_n = 1'b1;
    tick  = 1'b1;
    cyc();
    tick = 1'b0;
    chk("post_rst_prog", 32'(prog), 32'd0);
    chk("post_rst_valid", 32'(valid), 32'd0);
    start_game(2'd0, 0);
    do_tick(0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
